// File: rtl/call_scheduler_if.sv
// call_scheduler_if: raw call buttons, floor/door status and target outputs of the call scheduler
interface call_scheduler_if;
  logic       A_e, B_e, C_e;
  logic       A_i, B_i, C_i;
  logic [1:0] EA;
  logic       door;
  logic       B0, B1;
  logic       call_valid;
  logic       dir_up;
  logic [2:0] pend_ext;
  logic [2:0] pend_int;
  modport slave (
    input  A_e, B_e, C_e, A_i, B_i, C_i, EA, door,
    output B0, B1, call_valid, dir_up, pend_ext, pend_int
  );
  modport master (
    output A_e, B_e, C_e, A_i, B_i, C_i, EA, door,
    input  B0, B1, call_valid, dir_up, pend_ext, pend_int
  );
endinterface

// File: rtl/call_scheduler.sv
// call_scheduler: debounced call latching and sweep-policy target selection (INTERNAL_PRIORITY_EN serves internal calls first)
module call_scheduler #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input logic             clk,
  input logic             reset,
  call_scheduler_if.slave bus
);
  localparam logic [3:0] DEB = 4'(DEB_CYCLES);
  logic [5:0] raw, synced, press;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [3:0] cnt_q [6];
  logic [2:0] pend_ext_q, pend_int_q, clr, pending, sel, cur, up_s, dn_s;
  logic [1:0] tgt_q, tgt_d, up_t, dn_t;
  logic       dir_q, dir_d, valid_q, d;
  assign raw    = {bus.C_i, bus.B_i, bus.A_i, bus.C_e, bus.B_e, bus.A_e};
  assign synced = sync_q[SYNC_STAGES-1];
  // synchroniser chain for all six buttons
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // saturating debounce counters; saturation keeps a held button from firing again
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    else for (int i = 0; i < 6; i++) cnt_q[i] <= !synced[i] ? 4'd0 : cnt_q[i] == DEB ? DEB : cnt_q[i] + 4'd1;
  // a press is the single cycle in which the counter reaches DEB; service clear on an open door at a valid floor
  always_comb begin
    press = '0;
    for (int i = 0; i < 6; i++) press[i] = synced[i] && cnt_q[i] == DEB - 4'd1;
    clr = (!bus.door && bus.EA != 2'd3) ? 3'(3'b001 << bus.EA) : 3'b000;
  end
  // pending call latches; clear dominates a same-cycle press
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend_ext_q <= '0;
      pend_int_q <= '0;
    end else begin
      pend_ext_q <= (pend_ext_q | press[2:0]) & ~clr;
      pend_int_q <= (pend_int_q | press[5:3]) & ~clr;
    end
  // sweep selection: keep going in the effective direction, reverse only when nothing lies ahead
  always_comb begin
    pending = pend_ext_q | pend_int_q;
`ifdef INTERNAL_PRIORITY_EN
    sel = |pend_int_q ? pend_int_q : pending;
`else
    sel = pending;
`endif
    cur   = 3'(3'b001 << bus.EA);
    up_s  = sel & (bus.EA == 2'd0 ? 3'b110 : bus.EA == 2'd1 ? 3'b100 : 3'b000);
    dn_s  = sel & (bus.EA == 2'd2 ? 3'b011 : bus.EA == 2'd1 ? 3'b001 : 3'b000);
    up_t  = up_s[1] ? 2'd1 : 2'd2;
    dn_t  = dn_s[1] ? 2'd1 : 2'd0;
    d     = bus.EA == 2'd0 ? 1'b1 : bus.EA == 2'd2 ? 1'b0 : dir_q;
    dir_d = bus.EA == 2'd3 ? dir_q : d;
    tgt_d = tgt_q;
    if (bus.EA != 2'd3 && |sel) begin
      if (sel == cur) tgt_d = bus.EA;
      else if (d ? |up_s : |dn_s) tgt_d = d ? up_t : dn_t;
      else begin
        dir_d = !d;
        tgt_d = d ? dn_t : up_t;
      end
    end
  end
  // registered target, direction and call_valid
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tgt_q   <= 2'd0;
      dir_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
      valid_q <= |pending;
    end
  assign bus.B1         = tgt_q[1];
  assign bus.B0         = tgt_q[0];
  assign bus.call_valid = valid_q;
  assign bus.dir_up     = dir_q;
  assign bus.pend_ext   = pend_ext_q;
  assign bus.pend_int   = pend_int_q;
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed scenarios plus random button/floor traffic against a behavioural model
module tb_call_scheduler;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  logic       clk = 0, reset = 0;
  logic [5:0] btn = '0;
  logic [1:0] ea = '0;
  logic       door = 1'b1;
  int checks = 0, failures = 0;
  call_scheduler_if bus();
  assign {bus.C_i, bus.B_i, bus.A_i, bus.C_e, bus.B_e, bus.A_e} = btn;
  assign bus.EA   = ea;
  assign bus.door = door;
  call_scheduler #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [5:0] m_q[$];
  int         m_run[6];
  logic [2:0] m_ext, m_int;
  int         m_tgt;
  bit         m_dir, m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q = {};
    for (int i = 0; i < SYNC; i++) m_q.push_back(6'b0);
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_ext = 0; m_int = 0; m_tgt = 0; m_dir = 1; m_valid = 0;
  endtask

  function automatic int nearest(input logic [2:0] s, input int e, input bit up);
    for (int k = 1; k <= 2; k++) begin
      int f = up ? e + k : e - k;
      if (f >= 0 && f <= 2 && s[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [2:0] pend, sel, clr;
    logic [5:0] syn, prs;
    int e, f;
    bit d;
    e = int'(ea);
    pend = m_ext | m_int;
`ifdef INTERNAL_PRIORITY_EN
    sel = (m_int != 0) ? m_int : pend;
`else
    sel = pend;
`endif
    if (e != 3) begin
      d = (e == 0) ? 1'b1 : (e == 2) ? 1'b0 : m_dir;
      if (sel != 0) begin
        if (sel == 3'(1 << e)) m_tgt = e;
        else begin
          f = nearest(sel, e, d);
          if (f < 0) begin
            d = !d;
            f = nearest(sel, e, d);
          end
          m_tgt = f;
        end
      end
      m_dir = d;
    end
    m_valid = pend != 0;
    syn = m_q[0];
    m_q.push_back(btn);
    void'(m_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      m_run[i] = syn[i] ? (m_run[i] < 1000 ? m_run[i] + 1 : 1000) : 0;
      prs[i] = m_run[i] == DEB;
    end
    clr = (!door && e != 3) ? 3'(1 << e) : 3'b0;
    m_ext = (m_ext | prs[2:0]) & ~clr;
    m_int = (m_int | prs[5:3]) & ~clr;
  endtask

  task automatic compare();
    check("pend_ext", bus.pend_ext, m_ext);
    check("pend_int", bus.pend_int, m_int);
    check("target", {bus.B1, bus.B0}, m_tgt);
    check("call_valid", bus.call_valid, m_valid);
    check("dir_up", bus.dir_up, m_dir);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (reset) model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic hold(input logic [5:0] mask, input int n);
    btn = mask;
    step(n);
    btn = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0; btn = '0; ea = 0; door = 1;
    m_reset();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    m_reset();
    // reset held low with all buttons pulsed
    repeat (2) @(negedge clk);
    btn = 6'h3f;
    repeat (5) @(negedge clk);
    btn = '0;
    check("rst_pend_ext", bus.pend_ext, 3'b000);
    check("rst_pend_int", bus.pend_int, 3'b000);
    check("rst_target", {bus.B1, bus.B0}, 2'b00);
    check("rst_call_valid", bus.call_valid, 1'b0);
    check("rst_dir_up", bus.dir_up, 1'b1);
    @(negedge clk);
    reset = 1;
    step(10);
    check("idle_call_valid", bus.call_valid, 1'b0);
    // short pulse is rejected, a long one latches once
    hold(6'b000100, 3);
    step(8);
    check("short_no_latch", bus.pend_ext, 3'b000);
    btn = 6'b000100;
    step(6);
    check("long_latch", bus.pend_ext, 3'b100);
    step(1);
    check("long_target", {bus.B1, bus.B0}, 2'b10);
    check("long_valid", bus.call_valid, 1'b1);
    step(20);
    ea = 2; door = 0;
    step(1);
    ea = 0; door = 1;
    step(24);
    check("held_no_refire", bus.pend_ext, 3'b000);
    btn = '0;
    step(4);
    // sweep up past a lower call, then reverse at C
    do_reset();
    ea = 1;
    hold(6'b001100, 6);
    check("sweep_ext", bus.pend_ext, 3'b100);
    check("sweep_int", bus.pend_int, 3'b001);
    step(1);
    check("sweep_up_target", {bus.B1, bus.B0}, 2'b10);
    ea = 2; door = 0;
    step(1);
    check("serve_c_clear", bus.pend_ext, 3'b000);
    step(1);
    check("reverse_dir", bus.dir_up, 1'b0);
    check("reverse_target", {bus.B1, bus.B0}, 2'b00);
    // press at the open-door floor is swallowed by the clear
    do_reset();
    ea = 1; door = 0;
    hold(6'b010000, 6);
    step(2);
    check("clear_wins", bus.pend_int, 3'b000);
    door = 1;
    hold(6'b010000, 6);
    check("closed_latch", bus.pend_int, 3'b010);
    step(1);
    check("current_target", {bus.B1, bus.B0}, 2'b01);
    // internal-priority selection
    do_reset();
    hold(6'b100010, 6);
    step(1);
`ifdef INTERNAL_PRIORITY_EN
    check("priority_target", {bus.B1, bus.B0}, 2'b10);
`else
    check("priority_target", {bus.B1, bus.B0}, 2'b01);
`endif
    // asynchronous reset mid-cycle drops everything immediately
    do_reset();
    hold(6'b000111, 6);
    step(1);
    check("all_pending", bus.pend_ext, 3'b111);
    @(negedge clk);
    #2 reset = 0;
    #1;
    check("async_pend_ext", bus.pend_ext, 3'b000);
    check("async_pend_int", bus.pend_int, 3'b000);
    check("async_target", {bus.B1, bus.B0}, 2'b00);
    m_reset();
    @(negedge clk);
    reset = 1;
    // random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 6; i++) if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      if ($urandom_range(0, 5) == 0) begin
        ea = 2'($urandom_range(0, 3));
        door = ($urandom_range(0, 3) != 0);
      end
      step(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
